// File: rtl/btn_pkg.sv
// Shared constants and types for the pan/tilt button conditioner.
// Bit order of every 4-bit button bus: Up, Down, Left, Right.
package btn_pkg;

  localparam int BTN_UP    = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_LEFT  = 2;
  localparam int BTN_RIGHT = 3;
  localparam int N_BTN     = 4;

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    REPEAT
  } hold_state_e;

endpackage

// File: rtl/btn_channel.sv
// One button: 2-flop synchroniser, debounce counter, then a hold FSM
// that emits a press pulse followed by auto-repeat pulses.
module btn_channel
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_RATE     = 5000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic level,
  output logic raw_pulse
);

  localparam int CW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TMAX = (REPEAT_DELAY > REPEAT_RATE) ?
                        REPEAT_DELAY : REPEAT_RATE;
  localparam int TW   = $clog2(TMAX);

  localparam logic [CW-1:0] DB_MAX     = CW'(DEBOUNCE_CYCLES);
  localparam logic [TW-1:0] LOAD_DELAY = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0] LOAD_RATE  = TW'(REPEAT_RATE - 1);

  logic [1:0]    sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          rise, fall;

  hold_state_e   state_q;
  logic [TW-1:0] timer_q;
  logic          pulse_q;

  // Level flips on the cycle after the counter has seen
  // DEBOUNCE_CYCLES consecutive disagreements.
  always_comb begin
    sync_d  = {sync_q[0], btn_raw};
    cnt_d   = '0;
    level_d = level_q;
    if (sync_q[1] != level_q) begin
      if (cnt_q == DB_MAX) level_d = ~level_q;
      else                 cnt_d   = cnt_q + CW'(1);
    end
    rise = level_d & ~level_q;
    fall = ~level_d & level_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  // Release wins over a coincident timer expiry: no pulse on release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      timer_q <= '0;
      pulse_q <= 1'b0;
    end else begin
      pulse_q <= 1'b0;
      if (fall) begin
        state_q <= IDLE;
        timer_q <= '0;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (rise) begin
              pulse_q <= 1'b1;
              timer_q <= LOAD_DELAY;
              state_q <= DELAY;
            end
          end
          DELAY, REPEAT: begin
            if (timer_q == '0) begin
              pulse_q <= 1'b1;
              timer_q <= LOAD_RATE;
              state_q <= REPEAT;
            end else begin
              timer_q <= timer_q - TW'(1);
            end
          end
          default: begin
            state_q <= IDLE;
            timer_q <= '0;
          end
        endcase
      end
    end
  end

  assign level     = level_q;
  assign raw_pulse = pulse_q;

endmodule

// File: rtl/btn_conditioner.sv
// Four conditioned buttons with per-cycle cancellation of
// opposing step requests (Up/Down, Left/Right).
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_RATE     = 5000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] step_pulse,
  output logic             any_held
);

  logic [N_BTN-1:0] level_w;
  logic [N_BTN-1:0] raw_w;
  logic [N_BTN-1:0] step_q, step_d;
  logic             any_q, any_d;

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_RATE    (REPEAT_RATE)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .btn_raw  (btn_raw[i]),
      .level    (level_w[i]),
      .raw_pulse(raw_w[i])
    );
  end

  always_comb begin
    step_d            = '0;
    step_d[BTN_UP]    = raw_w[BTN_UP]    & ~raw_w[BTN_DOWN];
    step_d[BTN_DOWN]  = raw_w[BTN_DOWN]  & ~raw_w[BTN_UP];
    step_d[BTN_LEFT]  = raw_w[BTN_LEFT]  & ~raw_w[BTN_RIGHT];
    step_d[BTN_RIGHT] = raw_w[BTN_RIGHT] & ~raw_w[BTN_LEFT];
    any_d             = |level_w;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_q <= '0;
      any_q  <= 1'b0;
    end else begin
      step_q <= step_d;
      any_q  <= any_d;
    end
  end

  assign btn_level  = level_w;
  assign step_pulse = step_q;
  assign any_held   = any_q;

endmodule
